// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the pipeline sequencer: FSM state encoding, stall-cause
// codes reported to the core, counter widths and a saturating increment.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LDSTALL = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_MEMWAIT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'b00,
      CAUSE_LDUSE = 2'b01,
      CAUSE_FLUSH = 2'b10,
      CAUSE_MEMW  = 2'b11
   } cause_t;

   // Stall/flush countdown covers up to 7 cycles; wait counter is 8 bits
   localparam int CNT_W  = 3;
   localparam int WCNT_W = 8;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [WCNT_W-1:0] sat_inc8(input logic [WCNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// -----------------------------------------------------------------------------
// pipe_perf_cnt
// Optional performance counters for the pipeline sequencer. Only exists when
// the macro PIPE_PERF_EN is defined.
// Ports:
//   clk_i        core clock
//   rst_ni       asynchronous active-low reset
//   stall_i      this cycle the PC was held while the sequencer was ready
//   flush_i      a taken branch was accepted this cycle
//   stall_cyc_o  saturating count of stalled cycles
//   flush_cnt_o  saturating count of accepted branch flushes
// -----------------------------------------------------------------------------
`ifdef PIPE_PERF_EN
module pipe_perf_cnt (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic [31:0] stall_cyc_o,
   output logic [15:0] flush_cnt_o
);

   logic [31:0] stall_q;
   logic [15:0] flush_q;

   // Both counters stop at their maximum so a long run never reports a
   // small wrapped value
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_i && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
         end
         if (flush_i && (flush_q != '1)) begin
            flush_q <= flush_q + 16'd1;
         end
      end
   end

   assign stall_cyc_o = stall_q;
   assign flush_cnt_o = flush_q;

endmodule
`endif

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Central pipeline sequencer for the 5-stage core. Merges the load-use stall
// request, the EX-stage taken-branch redirect and the data-memory busy signal
// into per-stage enable, bubble and flush controls. Outputs are Mealy: a
// request takes effect in the same cycle it is raised.
// Priority: dmem_busy > br_taken_EX > ld_use_hz.
// Ports:
//   CLK, RSTN        clock, asynchronous active-low reset
//   ld_use_hz        load-use hazard in ID (level)
//   br_taken_EX      taken branch/jump resolved in EX (pulse)
//   dmem_busy        data memory not ready, EX/MEM must hold
//   pc_en, ifid_en   PC and IF/ID load enables
//   ifid_flush       clear IF/ID to NOP
//   idex_bubble      load NOP into ID/EX
//   exmem_en         EX/MEM and MEM/WB load enable
//   stall_cause      00 none, 01 load-use, 10 branch flush, 11 memory wait
//   wait_tmo         sticky memory-wait timeout, cleared only by reset
// Optional feature macro PIPE_PERF_EN adds perf_stall_cyc / perf_flush_cnt.
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
   import pipe_pkg::*;
#(
   parameter int LD_STALL_CYC = 1,
   parameter int FLUSH_CYC    = 1,
   parameter int WAIT_MAX     = 255
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        ld_use_hz,
   input  logic        br_taken_EX,
   input  logic        dmem_busy,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        exmem_en,
   output logic [1:0]  stall_cause,
   output logic        wait_tmo
`ifdef PIPE_PERF_EN
   ,
   output logic [31:0] perf_stall_cyc,
   output logic [15:0] perf_flush_cnt
`endif
);

   localparam logic [CNT_W-1:0]  LD_INIT    = CNT_W'(LD_STALL_CYC - 1);
   localparam logic [CNT_W-1:0]  FLUSH_INIT = CNT_W'(FLUSH_CYC - 1);
   localparam logic [WCNT_W-1:0] WAIT_LIM   = WCNT_W'(WAIT_MAX);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              tmo_q, tmo_d;
   logic              rdy_q;
   cause_t            cause;

   // Next-state and output decode. Nothing is driven until rdy_q is set on
   // the first edge after reset release. A memory wait freezes everything
   // and throws away any pending stall/flush countdown. Once the wait ends
   // (or outside any wait) the branch wins over the countdowns, so a branch
   // during a load-use stall restarts as a fresh flush. wcnt_d is the number
   // of consecutive busy cycles including the current one.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wcnt_d      = wcnt_q;
      tmo_d       = tmo_q;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_en    = 1'b0;
      cause       = CAUSE_NONE;

      if (rdy_q) begin
         pc_en    = 1'b1;
         ifid_en  = 1'b1;
         exmem_en = 1'b1;

         if (dmem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            exmem_en = 1'b0;
            cause    = CAUSE_MEMW;
            state_d  = ST_MEMWAIT;
            cnt_d    = '0;
            wcnt_d   = sat_inc8(wcnt_q);
            if (wcnt_d >= WAIT_LIM) begin
               tmo_d = 1'b1;
            end
         end else begin
            wcnt_d = '0;
            if (br_taken_EX) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               cause       = CAUSE_FLUSH;
               cnt_d       = FLUSH_INIT;
               state_d     = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
            end else if (state_q == ST_FLUSH) begin
               ifid_flush = 1'b1;
               cause      = CAUSE_FLUSH;
               cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
               state_d    = (cnt_q <= 1) ? ST_RUN : ST_FLUSH;
            end else if ((state_q == ST_LDSTALL) || ld_use_hz) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_bubble = 1'b1;
               cause       = CAUSE_LDUSE;
               if (state_q == ST_LDSTALL) begin
                  cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
                  state_d = (cnt_q <= 1) ? ST_RUN : ST_LDSTALL;
               end else begin
                  cnt_d   = LD_INIT;
                  state_d = (LD_STALL_CYC > 1) ? ST_LDSTALL : ST_RUN;
               end
            end else begin
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
      end
   end

   assign stall_cause = cause;
   assign wait_tmo    = tmo_q;

   // State, countdowns and the sticky timeout. Reset aborts any stall at once.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         tmo_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         rdy_q   <= 1'b1;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         tmo_q   <= tmo_d;
      end
   end

`ifdef PIPE_PERF_EN
   // A branch presented together with dmem_busy is not accepted, so it is
   // not counted as a flush
   pipe_perf_cnt u_perf (
      .clk_i       (CLK),
      .rst_ni      (RSTN),
      .stall_i     (rdy_q & ~pc_en),
      .flush_i     (rdy_q & br_taken_EX & ~dmem_busy),
      .stall_cyc_o (perf_stall_cyc),
      .flush_cnt_o (perf_flush_cnt)
   );
`endif

endmodule
